// File: rtl/ps2_key_pkg.sv
// PS/2 set-2 keyboard package: scancodes, editor key codes, FSM encodings
// and the scancode-to-key lookup shared by the decoder.
package ps2_key_pkg;

  // scancodes with special meaning to the decoder
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // editor key codes
  localparam logic [7:0] K_PGUP      = 8'h01;
  localparam logic [7:0] K_HOME      = 8'h02;
  localparam logic [7:0] K_END       = 8'h03;
  localparam logic [7:0] K_PGDN      = 8'h04;
  localparam logic [7:0] K_BACKSPACE = 8'h08;
  localparam logic [7:0] K_TAB       = 8'h09;
  localparam logic [7:0] K_ENTER     = 8'h0D;
  localparam logic [7:0] K_UP        = 8'h11;
  localparam logic [7:0] K_DOWN      = 8'h12;
  localparam logic [7:0] K_LEFT      = 8'h13;
  localparam logic [7:0] K_RIGHT     = 8'h14;
  localparam logic [7:0] K_F1        = 8'h15;
  localparam logic [7:0] K_F11       = 8'h1F;
  localparam logic [7:0] K_SPACE     = 8'h20;
  localparam logic [7:0] K_DEL       = 8'h7F;
  localparam logic [7:0] K_DIERESIS  = 8'hA8;
  localparam logic [7:0] K_TILDE     = 8'hB4;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK, D_SKIP} dec_state_t;

  // Translate a make code to an editor key code; 8'h00 means unmapped.
  function automatic logic [7:0] lookup(input logic [7:0] code, input logic ext,
                                        input logic shift, input logic caps);
    logic [7:0] r;
    logic [4:0] li;
    logic       lt;
    r  = 8'h00;
    li = 5'd0;
    lt = 1'b1;
    case (code)
      8'h1C: li = 5'd0;  8'h32: li = 5'd1;  8'h21: li = 5'd2;  8'h23: li = 5'd3;
      8'h24: li = 5'd4;  8'h2B: li = 5'd5;  8'h34: li = 5'd6;  8'h33: li = 5'd7;
      8'h43: li = 5'd8;  8'h3B: li = 5'd9;  8'h42: li = 5'd10; 8'h4B: li = 5'd11;
      8'h3A: li = 5'd12; 8'h31: li = 5'd13; 8'h44: li = 5'd14; 8'h4D: li = 5'd15;
      8'h15: li = 5'd16; 8'h2D: li = 5'd17; 8'h1B: li = 5'd18; 8'h2C: li = 5'd19;
      8'h3C: li = 5'd20; 8'h2A: li = 5'd21; 8'h1D: li = 5'd22; 8'h22: li = 5'd23;
      8'h35: li = 5'd24; 8'h1A: li = 5'd25;
      default: lt = 1'b0;
    endcase
    if (ext) begin
      case (code)
        8'h75: r = K_UP;
        8'h72: r = K_DOWN;
        8'h6B: r = K_LEFT;
        8'h74: r = K_RIGHT;
        8'h6C: r = K_HOME;
        8'h69: r = K_END;
        8'h7D: r = K_PGUP;
        8'h7A: r = K_PGDN;
        8'h71: r = K_DEL;
        8'h5A: r = K_ENTER;
        default: r = 8'h00;
      endcase
    end else if (lt) begin
      r = ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, li};
    end else begin
      // digit row follows the Spanish layout for shifted symbols
      case (code)
        8'h16: r = shift ? 8'h21 : 8'h31;
        8'h1E: r = shift ? 8'h22 : 8'h32;
        8'h26: r = shift ? 8'h23 : 8'h33;
        8'h25: r = shift ? 8'h24 : 8'h34;
        8'h2E: r = shift ? 8'h25 : 8'h35;
        8'h36: r = shift ? 8'h26 : 8'h36;
        8'h3D: r = shift ? 8'h2F : 8'h37;
        8'h3E: r = shift ? 8'h28 : 8'h38;
        8'h46: r = shift ? 8'h29 : 8'h39;
        8'h45: r = shift ? 8'h3D : 8'h30;
        8'h29: r = K_SPACE;
        8'h66: r = K_BACKSPACE;
        8'h0D: r = K_TAB;
        8'h5A: r = K_ENTER;
        8'h52: r = shift ? K_DIERESIS : K_TILDE;
        8'h05: r = 8'h15;
        8'h06: r = 8'h16;
        8'h04: r = 8'h17;
        8'h0C: r = 8'h18;
        8'h03: r = 8'h19;
        8'h0B: r = 8'h1A;
        8'h83: r = 8'h1B;
        8'h0A: r = 8'h1C;
        8'h01: r = 8'h1D;
        8'h09: r = 8'h1E;
        8'h78: r = K_F11;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk stability filter,
// start/data/parity/stop FSM and mid-frame watchdog.
// PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are discarded.
module ps2_rx
  import ps2_key_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic          w_fall, w_din;

  rx_state_t     r_state, w_state_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic [WW-1:0] r_wd, w_wd_n;
  logic          r_valid, w_valid_n;
  logic          r_err, w_err_n;

  assign w_din  = r_dat_sync[1];
  assign w_fall = r_filt_d & ~r_filt;

  // 2-FF synchronisers; both pins idle high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  // filtered clock follows the synced pin only after FILTER_LEN stable cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_sync[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FLT_MAX) begin
        r_filt <= r_clk_sync[1];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  // receiver state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= RX_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_wd     <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_wd     <= w_wd_n;
      r_valid  <= w_valid_n;
      r_err    <= w_err_n;
    end
  end

  // receiver next state; the watchdog wins over an edge landing in the same cycle
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_n    = r_par;
    w_valid_n  = 1'b0;
    w_err_n    = 1'b0;
    w_wd_n     = (r_state == RX_IDLE) ? '0 : r_wd + WW'(1);
    if (r_state != RX_IDLE && r_wd == WD_MAX) begin
      w_state_n = RX_IDLE;
      w_err_n   = 1'b1;
      w_wd_n    = '0;
    end else if (w_fall) begin
      w_wd_n = '0;
      case (r_state)
        RX_IDLE: begin
          if (!w_din) begin
            w_state_n  = RX_DATA;
            w_bitcnt_n = '0;
          end
        end
        RX_DATA: begin
          w_shift_n  = {w_din, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_n = RX_PAR;
        end
        RX_PAR: begin
          w_par_n   = w_din;
          w_state_n = RX_STOP;
        end
        RX_STOP: begin
          w_state_n = RX_IDLE;
          if (!w_din) begin
            w_err_n = 1'b1;
          end else begin
`ifdef PS2_PARITY_CHECK_EN
            if (^{r_shift, r_par}) w_valid_n = 1'b1;
            else                   w_err_n   = 1'b1;
`else
            w_valid_n = 1'b1;
`endif
          end
        end
        default: w_state_n = RX_IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_shift;
  assign o_rx_err     = r_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receiver plus set-2 decoder tracking E0/F0/E1
// prefixes, shift and caps lock, emitting editor key codes.
// PS2_PARITY_CHECK_EN (in ps2_rx) enables parity rejection.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       new_key,
  output logic [7:0] ascii,
  output logic       caps_on,
  output logic       frame_err
);

  logic       w_byte_valid, w_rx_err;
  logic [7:0] w_byte;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk        (sys_clk),
    .i_rst_n      (sys_rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte),
    .o_rx_err     (w_rx_err)
  );

  dec_state_t r_dstate, w_dstate_n;
  logic [2:0] r_skip, w_skip_n;
  logic       r_shift, w_shift_n;
  logic       r_caps, w_caps_n;
  logic       r_new_key, w_emit;
  logic [7:0] r_ascii, w_code;
  logic       w_is_shift;

  assign w_is_shift = (w_byte == SC_LSHIFT) || (w_byte == SC_RSHIFT);
  assign w_code     = lookup(w_byte, r_dstate == D_EXT, r_shift, r_caps);

  // decoder state, modifiers and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dstate  <= D_IDLE;
      r_skip    <= '0;
      r_shift   <= 1'b0;
      r_caps    <= 1'b0;
      r_new_key <= 1'b0;
      r_ascii   <= 8'h00;
    end else begin
      r_dstate  <= w_dstate_n;
      r_skip    <= w_skip_n;
      r_shift   <= w_shift_n;
      r_caps    <= w_caps_n;
      r_new_key <= w_emit;
      if (w_emit) r_ascii <= w_code;
    end
  end

  // prefix tracking and key emission, one step per received byte
  always_comb begin
    w_dstate_n = r_dstate;
    w_skip_n   = r_skip;
    w_shift_n  = r_shift;
    w_caps_n   = r_caps;
    w_emit     = 1'b0;
    if (w_byte_valid) begin
      case (r_dstate)
        D_IDLE: begin
          if (w_byte == SC_E0) begin
            w_dstate_n = D_EXT;
          end else if (w_byte == SC_F0) begin
            w_dstate_n = D_BRK;
          end else if (w_byte == SC_E1) begin
            // pause sequence: swallow the 7 bytes that follow E1
            w_dstate_n = D_SKIP;
            w_skip_n   = 3'd7;
          end else if (w_is_shift) begin
            w_shift_n = 1'b1;
          end else if (w_byte == SC_CAPS) begin
            w_caps_n = ~r_caps;
          end else begin
            w_emit = (w_code != 8'h00);
          end
        end
        D_EXT: begin
          if (w_byte == SC_F0) begin
            w_dstate_n = D_EXT_BRK;
          end else if (w_byte != SC_E0) begin
            w_emit     = (w_code != 8'h00);
            w_dstate_n = D_IDLE;
          end
        end
        D_BRK: begin
          if (w_is_shift) w_shift_n = 1'b0;
          w_dstate_n = D_IDLE;
        end
        D_EXT_BRK: w_dstate_n = D_IDLE;
        D_SKIP: begin
          w_skip_n = r_skip - 3'd1;
          if (r_skip == 3'd1) w_dstate_n = D_IDLE;
        end
        default: w_dstate_n = D_IDLE;
      endcase
    end
  end

  assign new_key   = r_new_key;
  assign ascii     = r_ascii;
  assign caps_on   = r_caps;
  assign frame_err = w_rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of scancode sequences with
// expected key output, plus hand sequences for timeout, parity, bad stop,
// glitch filtering and mid-frame reset.
module tb_ps2_key_decoder;

  localparam int TO = 3000;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       new_key;
  logic [7:0] ascii;
  logic       caps_on;
  logic       frame_err;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .new_key   (new_key),
    .ascii     (ascii),
    .caps_on   (caps_on),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int         total = 0;
  int         bad = 0;
  int         key_cnt = 0;
  int         err_cnt = 0;
  int         coinc = 0;
  logic [7:0] key_log [0:511];

  // output monitor, sampled away from the active edge
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (new_key) begin
        key_log[key_cnt[8:0]] <= ascii;
        key_cnt <= key_cnt + 1;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (new_key && frame_err) coinc <= coinc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge sys_clk);
    ps2_data = v;
    repeat (10) @(negedge sys_clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge sys_clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic frame(input logic [7:0] b, input bit bp, input bit bs, input int nbits);
    logic [10:0] bits;
    bits = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (40) @(negedge sys_clk);
  endtask

  typedef struct {
    logic [79:0] seq;
    int          n;
    int          nk;
    logic [7:0]  k;
    logic        caps;
  } vec_t;

  vec_t vt [24];
  int   nv;

  initial begin
    int k0, e0;
    logic [7:0] b;

    vt[0]  = '{80'h1CF01C,             3, 1, 8'h61, 1'b0};
    vt[1]  = '{80'h121CF012,           4, 1, 8'h41, 1'b0};
    vt[2]  = '{80'h581C,               2, 1, 8'h41, 1'b1};
    vt[3]  = '{80'h58,                 1, 0, 8'h00, 1'b0};
    vt[4]  = '{80'hE075,               2, 1, 8'h11, 1'b0};
    vt[5]  = '{80'hE0F075,             3, 0, 8'h00, 1'b0};
    vt[6]  = '{80'hE071,               2, 1, 8'h7F, 1'b0};
    vt[7]  = '{80'h52,                 1, 1, 8'hB4, 1'b0};
    vt[8]  = '{80'h5952F059,           4, 1, 8'hA8, 1'b0};
    vt[9]  = '{80'h16,                 1, 1, 8'h31, 1'b0};
    vt[10] = '{80'h1216F012,           4, 1, 8'h21, 1'b0};
    vt[11] = '{80'h123EF012,           4, 1, 8'h28, 1'b0};
    vt[12] = '{80'h05,                 1, 1, 8'h15, 1'b0};
    vt[13] = '{80'h78,                 1, 1, 8'h1F, 1'b0};
    vt[14] = '{80'h09,                 1, 1, 8'h1E, 1'b0};
    vt[15] = '{80'hE06B,               2, 1, 8'h13, 1'b0};
    vt[16] = '{80'hE01C,               2, 0, 8'h00, 1'b0};
    vt[17] = '{80'hE11477E1F014F0771C, 9, 1, 8'h61, 1'b0};
    vt[18] = '{80'h58121CF01258,       6, 1, 8'h61, 1'b0};
    vt[19] = '{80'h581658,             3, 1, 8'h31, 1'b0};
    vt[20] = '{80'h07,                 1, 0, 8'h00, 1'b0};
    vt[21] = '{80'h660D,               2, 2, 8'h09, 1'b0};
    vt[22] = '{80'h1A,                 1, 1, 8'h7A, 1'b0};
    vt[23] = '{80'h1C1C1C,             3, 3, 8'h61, 1'b0};
    nv = 24;

    // reset state
    repeat (4) @(negedge sys_clk);
    chk("rst_new_key", int'(new_key), 0);
    chk("rst_ascii", int'(ascii), 0);
    chk("rst_caps", int'(caps_on), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);

    // table-driven sequences
    for (int v = 0; v < nv; v++) begin
      k0 = key_cnt;
      e0 = err_cnt;
      for (int i = 0; i < vt[v].n; i++) begin
        b = vt[v].seq[8*(vt[v].n-1-i) +: 8];
        frame(b, 1'b0, 1'b0, 11);
      end
      repeat (20) @(negedge sys_clk);
      chk($sformatf("vec%0d_nkeys", v), key_cnt - k0, vt[v].nk);
      if (vt[v].nk > 0) begin
        chk($sformatf("vec%0d_key", v), int'(key_log[k0 + vt[v].nk - 1]), int'(vt[v].k));
        chk($sformatf("vec%0d_ascii_hold", v), int'(ascii), int'(vt[v].k));
      end
      chk($sformatf("vec%0d_caps", v), int'(caps_on), int'(vt[v].caps));
      chk($sformatf("vec%0d_noerr", v), err_cnt - e0, 0);
    end

    // watchdog: 5 bits then stall
    k0 = key_cnt; e0 = err_cnt;
    frame(8'hFF, 1'b0, 1'b0, 5);
    repeat (TO + 100) @(negedge sys_clk);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_nokey", key_cnt - k0, 0);
    frame(8'h29, 1'b0, 1'b0, 11);
    repeat (20) @(negedge sys_clk);
    chk("after_timeout_nkeys", key_cnt - k0, 1);
    chk("after_timeout_key", int'(key_log[k0]), 8'h20);
    chk("after_timeout_err", err_cnt - e0, 1);

    // flipped parity
    k0 = key_cnt; e0 = err_cnt;
    frame(8'h1C, 1'b1, 1'b0, 11);
    repeat (20) @(negedge sys_clk);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", err_cnt - e0, 1);
    chk("par_nokey", key_cnt - k0, 0);
`else
    chk("par_err", err_cnt - e0, 0);
    chk("par_nkeys", key_cnt - k0, 1);
    chk("par_key", int'(ascii), 8'h61);
`endif

    // bad stop bit
    k0 = key_cnt; e0 = err_cnt;
    frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (20) @(negedge sys_clk);
    chk("stop_err", err_cnt - e0, 1);
    chk("stop_nokey", key_cnt - k0, 0);

    // short ps2_clk glitch with data low must not start a frame
    k0 = key_cnt; e0 = err_cnt;
    @(negedge sys_clk);
    ps2_data = 1'b0;
    repeat (5) @(negedge sys_clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge sys_clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge sys_clk);
    ps2_data = 1'b1;
    repeat (40) @(negedge sys_clk);
    frame(8'h1C, 1'b0, 1'b0, 11);
    repeat (20) @(negedge sys_clk);
    chk("glitch_nkeys", key_cnt - k0, 1);
    chk("glitch_key", int'(key_log[k0]), 8'h61);
    chk("glitch_err", err_cnt - e0, 0);

    // reset mid-frame with shift and caps held
    frame(8'h12, 1'b0, 1'b0, 11);
    frame(8'h58, 1'b0, 1'b0, 11);
    chk("pre_rst_caps", int'(caps_on), 1);
    frame(8'h1C, 1'b0, 1'b0, 5);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("midrst_caps", int'(caps_on), 0);
    chk("midrst_ascii", int'(ascii), 0);
    chk("midrst_new_key", int'(new_key), 0);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    k0 = key_cnt; e0 = err_cnt;
    frame(8'h1C, 1'b0, 1'b0, 11);
    repeat (20) @(negedge sys_clk);
    chk("postrst_nkeys", key_cnt - k0, 1);
    chk("postrst_key", int'(key_log[k0]), 8'h61);
    chk("postrst_caps", int'(caps_on), 0);
    chk("postrst_err", err_cnt - e0, 0);

    chk("no_coincidence", coinc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
